// File: rtl/debouncer_pkg.sv
// Shared types and constants for the multi-channel debouncer.
package debouncer_pkg;

  typedef enum logic [1:0] {
    STABLE   = 2'd0,
    CHECKING = 2'd1,
    LOCKOUT  = 2'd2
  } deb_state_e;

  localparam logic MODE_INTEGRATE = 1'b0;
  localparam logic MODE_LOCKOUT   = 1'b1;

endpackage

// File: rtl/debounce_channel.sv
// Single debouncer channel: synchroniser, integrate/lockout FSM, edge pulses.
// Long-press hold counter is present only when DEBOUNCER_LONG_PRESS_EN is defined.
module debounce_channel
  import debouncer_pkg::*;
#(
  parameter int unsigned W           = 24,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic         i_clock,
  input  logic         i_reset,
  input  logic [W-1:0] i_threshold,
  input  logic         i_mode,
  input  logic         i_bouncing,
`ifdef DEBOUNCER_LONG_PRESS_EN
  input  logic [W-1:0] i_long_press_counter,
  output logic         o_long_press_pulse,
`endif
  output logic         o_debounced,
  output logic         o_rise_pulse,
  output logic         o_fall_pulse,
  output logic         o_change_c
);

  logic [SYNC_STAGES-1:0] sync_q;
  deb_state_e             state_q, state_d;
  logic [W-1:0]           cnt_q, cnt_d;
  logic [W-1:0]           thr_q, thr_d;
  logic                   deb_q, rise_q, fall_q;
  logic                   mismatch;
  logic                   flip;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_bouncing};
    end
  end

  assign mismatch = sync_q[SYNC_STAGES-1] ^ deb_q;

  // Counters start at 1 on entry so the entry edge counts towards T.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    thr_d   = thr_q;
    flip    = 1'b0;
    unique case (state_q)
      STABLE: begin
        cnt_d = '0;
        if (mismatch) begin
          thr_d = i_threshold;
          if (i_threshold == '0) begin
            flip = 1'b1;
          end else if (i_mode == MODE_LOCKOUT) begin
            flip    = 1'b1;
            state_d = LOCKOUT;
            cnt_d   = W'(1);
          end else begin
            state_d = CHECKING;
            cnt_d   = W'(1);
          end
        end
      end
      CHECKING: begin
        if (!mismatch) begin
          state_d = STABLE;
          cnt_d   = '0;
        end else if (cnt_q == thr_q) begin
          flip    = 1'b1;
          state_d = STABLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + W'(1);
        end
      end
      LOCKOUT: begin
        if (cnt_q == thr_q) begin
          state_d = STABLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + W'(1);
        end
      end
      default: begin
        state_d = STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= STABLE;
      cnt_q   <= '0;
      thr_q   <= '0;
      deb_q   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      thr_q   <= thr_d;
      deb_q   <= deb_q ^ flip;
      rise_q  <= flip & ~deb_q;
      fall_q  <= flip & deb_q;
    end
  end

  assign o_debounced  = deb_q;
  assign o_rise_pulse = rise_q;
  assign o_fall_pulse = fall_q;
  assign o_change_c   = flip;

`ifdef DEBOUNCER_LONG_PRESS_EN
  logic [W-1:0] hold_q, hold_d;
  logic         lp_q, lp_d;

  // Hold counter saturates at the long-press count, so one pulse per press.
  always_comb begin
    hold_d = hold_q;
    lp_d   = 1'b0;
    if (flip) begin
      hold_d = '0;
    end else if (deb_q && (hold_q < i_long_press_counter)) begin
      hold_d = hold_q + W'(1);
      lp_d   = (hold_d == i_long_press_counter);
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      hold_q <= '0;
      lp_q   <= 1'b0;
    end else begin
      hold_q <= hold_d;
      lp_q   <= lp_d;
    end
  end

  assign o_long_press_pulse = lp_q;
`endif

endmodule

// File: rtl/multi_channel_debouncer.sv
// N-channel debouncer top: one debounce_channel per input plus a registered any-change flag.
// Optional long-press outputs are enabled by DEBOUNCER_LONG_PRESS_EN.
module multi_channel_debouncer
  import debouncer_pkg::*;
#(
  parameter int unsigned CHANNEL_COUNT          = 13,
  parameter int unsigned DEBOUNCE_COUNTER_WIDTH = 24,
  parameter int unsigned SYNC_STAGES            = 2
) (
  input  logic                              i_clock,
  input  logic                              i_reset,
  input  logic [DEBOUNCE_COUNTER_WIDTH-1:0] i_debounce_counter,
  input  logic [CHANNEL_COUNT-1:0]          i_mode,
  input  logic [CHANNEL_COUNT-1:0]          i_bouncing,
`ifdef DEBOUNCER_LONG_PRESS_EN
  input  logic [DEBOUNCE_COUNTER_WIDTH-1:0] i_long_press_counter,
  output logic [CHANNEL_COUNT-1:0]          o_long_press_pulse,
`endif
  output logic [CHANNEL_COUNT-1:0]          o_debounced,
  output logic [CHANNEL_COUNT-1:0]          o_rise_pulse,
  output logic [CHANNEL_COUNT-1:0]          o_fall_pulse,
  output logic                              o_any_change
);

  logic [CHANNEL_COUNT-1:0] change_c;
  logic                     any_change_q;

  for (genvar ch = 0; ch < CHANNEL_COUNT; ch++) begin : g_ch
    debounce_channel #(
      .W          (DEBOUNCE_COUNTER_WIDTH),
      .SYNC_STAGES(SYNC_STAGES)
    ) u_channel (
      .i_clock             (i_clock),
      .i_reset             (i_reset),
      .i_threshold         (i_debounce_counter),
      .i_mode              (i_mode[ch]),
      .i_bouncing          (i_bouncing[ch]),
`ifdef DEBOUNCER_LONG_PRESS_EN
      .i_long_press_counter(i_long_press_counter),
      .o_long_press_pulse  (o_long_press_pulse[ch]),
`endif
      .o_debounced         (o_debounced[ch]),
      .o_rise_pulse        (o_rise_pulse[ch]),
      .o_fall_pulse        (o_fall_pulse[ch]),
      .o_change_c          (change_c[ch])
    );
  end

  // Registered from the same flip conditions so it lines up with the pulses.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      any_change_q <= 1'b0;
    end else begin
      any_change_q <= |change_c;
    end
  end

  assign o_any_change = any_change_q;

endmodule

// File: doc/multi_channel_debouncer.md
Name: multi_channel_debouncer

Overview:
Parametrised N-channel debouncer for switches, buttons and any slow asynchronous level input.
- Each channel has its own input synchroniser and an independently selectable debounce mode: integrate or lockout.
- Each channel also produces registered rise and fall pulses.
- Sits between board pins and user logic. Replaces per-board fixed-count wrappers; board tops instantiate one or more of these with channel count sized to their I/O.

Parameters:
CHANNEL_COUNT, 13, number of independent channels (>=1)
DEBOUNCE_COUNTER_WIDTH, 24, width of debounce threshold and per-channel counters
SYNC_STAGES, 2, synchroniser flop depth per channel (>=2)

Ports:
i_clock  input  1  single clock for all logic
i_reset  input  1  synchronous, active-high reset
i_debounce_counter  input  DEBOUNCE_COUNTER_WIDTH  threshold T in clock cycles, shared by all channels
i_mode  input  CHANNEL_COUNT  per-channel mode; 0 = integrate, 1 = lockout
i_bouncing  input  CHANNEL_COUNT  raw asynchronous inputs
o_debounced  output  CHANNEL_COUNT  debounced levels
o_rise_pulse  output  CHANNEL_COUNT  1-cycle pulse when the debounced level goes 0->1
o_fall_pulse  output  CHANNEL_COUNT  1-cycle pulse when the debounced level goes 1->0
o_any_change  output  1  registered OR of all rise and fall pulses of the same cycle

Behaviour:
- Reset: the synchronous active-high reset on i_clock, sampled on the rising edge, puts the block in this state:
  - all synchroniser flops = 0, o_debounced = 0, o_rise_pulse = 0, o_fall_pulse = 0, o_any_change = 0
  - counters = 0, latched thresholds = 0, every channel FSM = STABLE
- Reset mid-operation: abandons any CHECKING/LOCKOUT in progress. No pulse is generated by reset itself.
- Synchroniser: SYNC_STAGES flops per channel; s = last stage. Mismatch condition: s != o_debounced[ch].
- Per-channel FSM states: STABLE, CHECKING, LOCKOUT.
- STABLE:
  - counter = 0; i_mode[ch] is sampled here only.
  - Mode changes while in CHECKING/LOCKOUT take effect on the next return to STABLE.
  - On mismatch, mode 0: latch T_l = i_debounce_counter, go to CHECKING; if T_l = 0, commit immediately, i.e. the output flips on the next edge and the FSM stays STABLE.
  - On mismatch, mode 1: flip o_debounced next edge, latch T_l, go to LOCKOUT; if T_l = 0, stay STABLE.
- CHECKING (integrate):
  - mismatch persists: counter increments.
  - counter reaches T_l while mismatch still holds: flip o_debounced, return to STABLE.
  - mismatch drops (glitch): counter cleared, return to STABLE, no output change.
- LOCKOUT:
  - input ignored; counter increments each cycle.
  - counter reaches T_l: return to STABLE.
  - If input is then mismatched, normal STABLE handling applies, so the output always converges to the settled input.
- Latency, i_bouncing edge to o_debounced edge:
  - integrate: SYNC_STAGES + T + 1 clock edges
  - lockout: SYNC_STAGES + 1 clock edges
- Threshold is latched at entry to CHECKING/LOCKOUT. Changing i_debounce_counter mid-count does not affect that count.
- Counter width equals DEBOUNCE_COUNTER_WIDTH. T = all-ones is legal; the counter never wraps because the terminal compare precedes increment.
- Pulses:
  - o_rise_pulse/o_fall_pulse are asserted in the same cycle o_debounced shows its new value, for exactly 1 cycle.
  - o_any_change is asserted in that same cycle.
- Channels are fully independent; simultaneous events on several channels each produce their own pulses.

Optional Feature:
Macro DEBOUNCER_LONG_PRESS_EN.
- Defined: adds ports i_long_press_counter (input, DEBOUNCE_COUNTER_WIDTH) and o_long_press_pulse (output, CHANNEL_COUNT), plus a per-channel hold counter.
  - The hold counter clears on any o_debounced change and counts while o_debounced = 1.
  - o_long_press_pulse[ch] asserts for 1 cycle when the hold counter reaches i_long_press_counter, then saturates: no repeat until release.
  - Reset value of the hold counters and o_long_press_pulse is 0.
- Undefined: neither port nor hold counter exists; the rest of the behaviour is identical.

Decomposition:
- Package debouncer_pkg holds:
  - typedef enum for STABLE/CHECKING/LOCKOUT
  - mode constants MODE_INTEGRATE = 1'b0, MODE_LOCKOUT = 1'b1
- One sub-module, debounce_channel: synchroniser, FSM, counter, pulse generation and optional long-press logic for a single channel.
- The top generates CHANNEL_COUNT instances and registers o_any_change.

Test Plan:
- Reset, then i_bouncing = 0 everywhere -> all outputs 0. Assert i_reset mid-CHECKING -> o_debounced stays 0, no pulses, FSM = STABLE.
- Integrate, T = 10, SYNC_STAGES = 2, ch0 0->1 held -> o_debounced[0] rises 13 edges later, o_rise_pulse[0] = 1 for exactly 1 cycle, o_any_change = 1 in that cycle.
- Integrate, T = 10, ch1 pulses high for 9 cycles then low -> no output change, no pulses.
- Lockout, T = 20, ch2 bounces 0/1 every 3 cycles for 15 cycles then settles at 1 -> o_debounced[2] rises 3 edges after the first edge, no further toggles, final value 1.
- Lockout, T = 5, input settles 0 immediately after the first edge -> output rises, then falls at lockout exit + 1, one rise and one fall pulse.
- With DEBOUNCER_LONG_PRESS_EN, T = 4, long = 50, ch3 held 1 for 200 cycles -> exactly one o_long_press_pulse[3], 50 cycles after the debounced rise; none after release/re-press shorter than 50.
